// File: rtl/prio_encoder_arb.sv
// prio_encoder_arb: registered N-input request arbiter with held grant.
//   Encodes req into a binary index plus one-hot grant, held until ack.
//   mode=0 selects fixed priority (highest index wins), mode=1 round-robin.
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous active-high reset
//   req[N-1:0]   - request vector, bit i = requester i
//   mode         - 0 fixed priority, 1 round-robin (sampled in IDLE only)
//   ack          - releases the current grant (ignored in IDLE)
//   grant_valid  - a grant is held
//   grant_idx    - binary index of the granted requester
//   grant_onehot - one-hot of the granted requester
//   busy_cycles  - saturating count of cycles spent in the current grant
module prio_encoder_arb #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic [7:0]   busy_cycles
);

  localparam int unsigned BUSY_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [W-1:0]        idx_q, idx_d;
  logic [N-1:0]        onehot_q, onehot_d;
  logic [BUSY_W-1:0]   busy_q, busy_d;
  logic [W-1:0]        rr_q, rr_d;

  logic [W-1:0]        fixed_win;
  logic [W-1:0]        rr_win;

  // Fixed priority: scan upward so the highest asserted index is kept.
  always_comb begin
    fixed_win = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (req[i]) fixed_win = W'(i);
    end
  end

  // Round-robin: scan offsets downward from rr_q so the nearest
  // asserted bit at or above the pointer (with wrap) is kept.
  always_comb begin
    int unsigned k;
    rr_win = '0;
    k      = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      k = int'(rr_q) + i;
      if (k >= N) k = k - N;
      if (req[k]) rr_win = W'(k);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      busy_q   <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      busy_q   <= busy_d;
      rr_q     <= rr_d;
    end
  end

  // Next-state logic; outputs hold by default while a grant is held.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    busy_d   = busy_q;
    rr_d     = rr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = GRANT;
          valid_d  = 1'b1;
          idx_d    = mode ? rr_win : fixed_win;
          onehot_d = N'(1) << (mode ? rr_win : fixed_win);
          busy_d   = '0;
        end
      end
      GRANT: begin
        if (ack) begin
          // Release wins over any pending request; IDLE bubble follows.
          state_d  = IDLE;
          valid_d  = 1'b0;
          idx_d    = '0;
          onehot_d = '0;
          busy_d   = '0;
          rr_d     = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
        end else if (busy_q != {BUSY_W{1'b1}}) begin
          busy_d = busy_q + BUSY_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_valid  = valid_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;
  assign busy_cycles  = busy_q;

endmodule
